// File: rtl/vdac_ctrl.sv
// VDAC front-end controller: serial configuration receiver, frame-aligned mode
// switching and registered pixel gating toward the conversion datapath.
module vdac_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] o_r,
    input  logic [4:0] o_g,
    input  logic [4:0] o_b,
    input  logic       blank,
    input  logic       vsync,
    input  logic       cfg_cs_n,
    input  logic       cfg_sclk,
    input  logic       cfg_mosi,
    output logic [4:0] d_r,
    output logic [4:0] d_g,
    output logic [4:0] d_b,
    output logic       mode,
    output logic       mode_pend
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_MODE  = 2'b00,
        CMD_BLANK = 2'b01,
        CMD_LEVEL = 2'b10,
        CMD_TEST  = 2'b11
    } cmd_t;

    // Synchronizer stages reset to the link's idle levels.
    logic r_cs_meta, r_cs_sync;
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_mosi_meta, r_mosi_sync;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       w_sclk_rise;
    logic       w_shift_en;
    logic       w_cnt_clr;

    logic       r_pend_mode;
    logic       r_force_blank;
    logic       r_test_en;
    logic [4:0] r_test_lvl;
    logic       r_vsync_prev;
    logic       w_vsync_rise;

    logic       w_exec;
    cmd_t       w_cmd;
    logic       w_force_blank_nxt;
    logic       w_test_en_nxt;
    logic [4:0] w_test_lvl_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of statements or blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_cs_meta   <= cfg_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_sclk_meta <= cfg_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= cfg_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_cs_sync) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_cs_sync) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = r_cs_sync ? ST_IDLE : ST_SHIFT;
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {r_shift[6:0], r_mosi_sync};
            end
        end
    end

    // The byte is complete in r_shift for the single EXEC cycle.
    assign w_exec = (r_state == ST_EXEC);
    assign w_cmd  = cmd_t'(r_shift[7:6]);

    always_comb begin
        w_force_blank_nxt = r_force_blank;
        w_test_en_nxt     = r_test_en;
        w_test_lvl_nxt    = r_test_lvl;
        if (w_exec) begin
            case (w_cmd)
                CMD_BLANK: w_force_blank_nxt = r_shift[0];
                CMD_LEVEL: w_test_lvl_nxt    = r_shift[4:0];
                CMD_TEST:  w_test_en_nxt     = r_shift[0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_force_blank <= 1'b1;
            r_test_en     <= 1'b0;
            r_test_lvl    <= 5'd0;
        end else begin
            r_force_blank <= w_force_blank_nxt;
            r_test_en     <= w_test_en_nxt;
            r_test_lvl    <= w_test_lvl_nxt;
        end
    end

    assign w_vsync_rise = vsync & ~r_vsync_prev;

    // A mode command landing on a frame edge promotes the older pending value
    // to mode while the new one waits for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_prev <= 1'b0;
            r_pend_mode  <= 1'b0;
            mode         <= 1'b0;
            mode_pend    <= 1'b0;
        end else begin
            r_vsync_prev <= vsync;
            if (w_vsync_rise && mode_pend) mode <= r_pend_mode;
            if (w_exec && w_cmd == CMD_MODE) begin
                r_pend_mode <= r_shift[0];
                mode_pend   <= 1'b1;
            end else if (w_vsync_rise) begin
                mode_pend <= 1'b0;
            end
        end
    end

    // Gating uses the post-EXEC configuration so changes show on d_* the
    // cycle after EXEC; values 25..31 pass through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r <= 5'd0;
            d_g <= 5'd0;
            d_b <= 5'd0;
        end else if (blank || w_force_blank_nxt) begin
            d_r <= 5'd0;
            d_g <= 5'd0;
            d_b <= 5'd0;
        end else if (w_test_en_nxt) begin
            d_r <= w_test_lvl_nxt;
            d_g <= w_test_lvl_nxt;
            d_b <= w_test_lvl_nxt;
        end else begin
            d_r <= o_r;
            d_g <= o_g;
            d_b <= o_b;
        end
    end

endmodule

// File: tb/tb_vdac_ctrl.sv
// Self-checking bench for vdac_ctrl: directed configuration sequences, a
// pixel-gating vector table and randomized traffic against a reference model.
module tb_vdac_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] o_r, o_g, o_b;
    logic       blank, vsync;
    logic       cfg_cs_n, cfg_sclk, cfg_mosi;
    logic [4:0] d_r, d_g, d_b;
    logic       mode, mode_pend;

    int n_cmp = 0;
    int n_err = 0;

    // Reference configuration, updated from each complete byte sent.
    logic       m_fb  = 1'b1;
    logic       m_te  = 1'b0;
    logic [4:0] m_lvl = 5'd0;

    typedef struct {
        logic [4:0] r, g, b;
        logic       bl;
        logic [14:0] exp_rgb;
    } vec_t;

    vec_t vecs[7];

    vdac_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .blank(blank), .vsync(vsync),
        .cfg_cs_n(cfg_cs_n), .cfg_sclk(cfg_sclk), .cfg_mosi(cfg_mosi),
        .d_r(d_r), .d_g(d_g), .d_b(d_b),
        .mode(mode), .mode_pend(mode_pend)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [14:0] model_rgb(input logic [4:0] r, g, b, input logic bl);
        if (bl || m_fb) return 15'd0;
        if (m_te) return {m_lvl, m_lvl, m_lvl};
        return {r, g, b};
    endfunction

    // Sends the first nbits of b MSB first; with vs_at_exec the vsync rise is
    // placed on the clock edge that ends EXEC of a full byte.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit vs_at_exec);
        cfg_cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < nbits; i++) begin
            cfg_mosi = b[7-i];
            repeat (3) tick();
            cfg_sclk = 1'b1;
            if (i == 7 && vs_at_exec) begin
                repeat (3) tick();
                vsync = 1'b1;
                tick();
            end else begin
                repeat (3) tick();
            end
            cfg_sclk = 1'b0;
        end
        repeat (3) tick();
        cfg_cs_n = 1'b1;
        repeat (6) tick();
        if (nbits == 8) begin
            case (b[7:6])
                2'b01:   m_fb  = b[0];
                2'b10:   m_lvl = b[4:0];
                2'b11:   m_te  = b[0];
                default: ;
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8, 1'b0);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{5'd3,  5'd17, 5'd9,  1'b0, {5'd3,  5'd17, 5'd9}};
        vecs[1] = '{5'd25, 5'd26, 5'd27, 1'b0, {5'd25, 5'd26, 5'd27}};
        vecs[2] = '{5'd31, 5'd30, 5'd29, 1'b0, {5'd31, 5'd30, 5'd29}};
        vecs[3] = '{5'd31, 5'd31, 5'd31, 1'b1, 15'd0};
        vecs[4] = '{5'd0,  5'd0,  5'd0,  1'b0, 15'd0};
        vecs[5] = '{5'd12, 5'd1,  5'd28, 1'b0, {5'd12, 5'd1,  5'd28}};
        vecs[6] = '{5'd7,  5'd8,  5'd24, 1'b1, 15'd0};

        rst_n = 1'b0;
        o_r = 5'd12; o_g = 5'd5; o_b = 5'd6;
        blank = 1'b0; vsync = 1'b0;
        cfg_cs_n = 1'b1; cfg_sclk = 1'b0; cfg_mosi = 1'b0;
        repeat (3) tick();
        check("reset_d", {d_r, d_g, d_b}, 15'd0);
        check("reset_mode", {mode, mode_pend}, 2'b00);
        rst_n = 1'b1;
        repeat (3) tick();
        check("force_blank_default_d_r", d_r, 5'd0);

        // Clear force_blank; pixel passes with one-clock latency.
        send_byte(8'h40);
        check("after_0x40_d_r", d_r, 5'd12);
        o_r = 5'd7;
        tick();
        check("latency1_d_r", d_r, 5'd7);

        // Test pattern level 10, then blank overrides it.
        send_byte(8'h8A);
        send_byte(8'hC1);
        check("test_lvl_rgb", {d_r, d_g, d_b}, {5'd10, 5'd10, 5'd10});
        blank = 1'b1;
        tick();
        check("blank_over_test", {d_r, d_g, d_b}, 15'd0);
        blank = 1'b0;
        tick();
        check("unblank_test", {d_r, d_g, d_b}, {5'd10, 5'd10, 5'd10});
        send_byte(8'hC0);

        for (int i = 0; i < 7; i++) begin
            o_r = vecs[i].r; o_g = vecs[i].g; o_b = vecs[i].b; blank = vecs[i].bl;
            tick();
            check($sformatf("vec%0d_rgb", i), {d_r, d_g, d_b}, vecs[i].exp_rgb);
        end
        blank = 1'b0;

        // Aborted byte after 5 bits executes nothing.
        send_bits(8'h01, 5, 1'b0);
        check("abort_mode_pend", mode_pend, 1'b0);
        check("abort_test_en_kept", d_r, o_r);
        send_byte(8'h01);
        check("full_0x01_pend", {mode, mode_pend}, 2'b01);

        // Mode command EXEC coinciding with a vsync rise.
        send_bits(8'h00, 8, 1'b1);
        check("coincide_mode", {mode, mode_pend}, 2'b11);
        vsync = 1'b0;
        tick();
        vsync_pulse();
        check("coincide_next_frame", {mode, mode_pend}, 2'b00);

        // Mid-frame mode change waits for vsync.
        send_byte(8'h01);
        check("midframe_pend", {mode, mode_pend}, 2'b01);
        vsync = 1'b1;
        tick();
        check("vsync_apply_same_edge", {mode, mode_pend}, 2'b10);
        vsync = 1'b0;
        tick();
        vsync_pulse();
        check("vsync_no_pend_hold", {mode, mode_pend}, 2'b10);

        // Randomized gating against the reference model.
        for (int seg = 0; seg < 6; seg++) begin
            logic [7:0] cmd;
            cmd = {2'($urandom_range(1, 3)), 6'($urandom)};
            send_byte(cmd);
            for (int c = 0; c < 30; c++) begin
                logic [14:0] exp_rgb;
                o_r = 5'($urandom); o_g = 5'($urandom); o_b = 5'($urandom);
                blank = ($urandom_range(0, 3) == 0);
                exp_rgb = model_rgb(o_r, o_g, o_b, blank);
                tick();
                check($sformatf("rand_s%0d_c%0d", seg, c), {d_r, d_g, d_b}, exp_rgb);
            end
        end
        blank = 1'b0;

        // Asynchronous reset mid-byte and mid-frame.
        send_byte(8'hC0);
        send_byte(8'h40);
        o_r = 5'd12; o_g = 5'd9; o_b = 5'd3;
        tick();
        check("pre_reset_state", {mode, d_r, d_g, d_b}, {1'b1, 5'd12, 5'd9, 5'd3});
        cfg_cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            cfg_mosi = 1'b1;
            repeat (3) tick();
            cfg_sclk = 1'b1;
            repeat (3) tick();
            cfg_sclk = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {mode, mode_pend, d_r, d_g, d_b}, 17'd0);
        cfg_cs_n = 1'b1;
        cfg_mosi = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        m_fb = 1'b1; m_te = 1'b0; m_lvl = 5'd0;
        check("post_reset_force_blank", {mode, mode_pend, d_r}, 7'd0);
        send_byte(8'h40);
        check("post_reset_fresh_byte", d_r, 5'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vdac_ctrl.md
VDAC_CTRL -- requirements
Module: vdac_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all logic on rising edge); rst_n input 1 (asynchronous assert, active-low).
REQ-002 SHALL have ports o_r, o_g, o_b, input 5 each: pixel components from the video generator, synchronous to clk.
REQ-003 SHALL have port blank, input 1: active-video blank flag, synchronous to clk.
REQ-004 SHALL have port vsync, input 1: frame sync, synchronous to clk, active-high.
REQ-005 SHALL have ports cfg_cs_n, cfg_sclk, cfg_mosi, input 1 each: asynchronous serial configuration link from host.
REQ-006 SHALL have ports d_r, d_g, d_b, output 5 each: gated pixel components to the VDAC conversion datapath.
REQ-007 SHALL have port mode, output 1: conversion select to datapath (0 = 25-level LUT, 1 = direct shift).
REQ-008 SHALL have port mode_pend, output 1: high while a mode change awaits the next frame.

Function
REQ-009 SHALL pass cfg_cs_n, cfg_sclk, cfg_mosi each through a 2-flop synchronizer before use.
REQ-010 SHALL detect an sclk rising edge as synced sclk = 1 while its previous sample = 0, and sample synced mosi on that cycle.
REQ-011 SHALL run the receiver FSM with states IDLE, SHIFT and EXEC.
- IDLE -> SHIFT: synced cs_n = 0.
- SHIFT: shift mosi in MSB first; 3-bit counter counts edges; 8th edge -> EXEC.
- EXEC: executes the byte for exactly one cycle, then SHIFT if cs_n = 0, else IDLE.
REQ-012 SHALL, when synced cs_n goes high in SHIFT, discard partial bits, clear the bit counter and return to IDLE with no command executed.
REQ-013 SHALL decode byte[7:6] in EXEC:
- 00: pend_mode <= byte[0]; mode_pend <= 1.
- 01: force_blank <= byte[0].
- 10: test_lvl <= byte[4:0].
- 11: test_en <= byte[0].
- All other bits ignored.
REQ-014 SHALL detect a vsync rising edge as vsync = 1 while registered prior vsync = 0.
REQ-015 SHALL, on a vsync rising edge with mode_pend = 1, load mode <= pend_mode and clear mode_pend on the same clock edge.
REQ-016 SHALL, when EXEC of a cmd-00 coincides with a vsync edge, apply the previously pending value (if any) to mode, load the new value into pend_mode, and leave mode_pend = 1 for the next frame.
REQ-017 SHALL never change mode except on a vsync rising edge.
REQ-018 SHALL register d_* with latency 1 clk using this priority:
- blank | force_blank -> 0;
- else test_en -> test_lvl on all three channels;
- else o_*.
REQ-019 SHALL pass o_* values 25..31 unmodified; clamping is the datapath's concern.
REQ-020 SHALL allow force_blank and test_* changes to take effect on d_* the cycle after EXEC, without frame alignment.

Reset
REQ-021 SHALL, while rst_n = 0, hold:
- d_r = d_g = d_b = 0, mode = 0, mode_pend = 0;
- pend_mode = 0, force_blank = 1, test_en = 0, test_lvl = 0;
- FSM = IDLE, bit counter = 0, synchronizers = idle levels (cs_n = 1, sclk = 0, mosi = 0).
REQ-022 SHALL, on reset assertion mid-byte, abandon the byte; after release, require a fresh cs_n low.

Verification
REQ-023 SHALL cover: after reset, o_r = 12, blank = 0 -> d_r = 0 (force_blank = 1); send byte 0x40 -> d_r = 12 starting 1 clk after EXEC, with 1-clk latency thereafter.
REQ-024 SHALL cover: send 0x01 mid-frame -> mode_pend = 1, mode = 0; next vsync rise -> mode = 1, mode_pend = 0 on the same edge.
REQ-025 SHALL cover: send 0x8A then 0xC1 with blank = 0, force_blank = 0 -> d_r = d_g = d_b = 10; blank = 1 -> all 0 the next clk.
REQ-026 SHALL cover: raise cs_n after 5 bits of 0x01 -> no command executes, mode_pend stays 0; the next full byte 0x01 is accepted correctly.
REQ-027 SHALL cover: cmd-00 EXEC on the same clk as a vsync rise with mode_pend = 1 and pend_mode = 1, new byte 0x00 -> mode = 1, pend_mode = 0, mode_pend = 1; next vsync -> mode = 0.
REQ-028 SHALL cover: assert rst_n = 0 asynchronously mid-byte and mid-frame -> all outputs at REQ-021 values immediately, without waiting for a clk edge.
